// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter in front of a FIFO with bounded bursts and a registered write port.
// Optional per-producer/overflow statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [FIFO_WIDTH-1:0] data_a,
    input  logic [FIFO_WIDTH-1:0] data_b,
    output logic                  accept_a,
    output logic                  accept_b,
    input  logic                  full,
    input  logic                  almostfull,
    input  logic                  overflow,
    output logic                  wr_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic [15:0]           wr_cnt_a,
    output logic [15:0]           wr_cnt_b,
    output logic [7:0]            ovf_cnt,
    output logic [1:0]            gnt_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    localparam logic [3:0] BURST_TOP = 4'(MAX_BURST - 1);

    state_e                  state_q, state_d;
    last_e                   last_q, last_d;
    logic [3:0]              burst_cnt_q, burst_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]   data_in_q, data_in_d;
    logic                    blocked;

    // almostfull only blocks when a write is already in flight to the FIFO
    assign blocked  = full | (almostfull & wr_en_q);
    assign accept_a = rst_n & (state_q == GNT_A) & req_a & ~blocked;
    assign accept_b = rst_n & (state_q == GNT_B) & req_b & ~blocked;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || last_q == LAST_B)) state_d = GNT_A;
                else if (req_b)                             state_d = GNT_B;
            end
            GNT_A: begin
                if (!req_a)                                          state_d = req_b ? GNT_B : IDLE;
                else if (accept_a && burst_cnt_q == BURST_TOP && req_b) state_d = GNT_B;
            end
            GNT_B: begin
                if (!req_b)                                          state_d = req_a ? GNT_A : IDLE;
                else if (accept_b && burst_cnt_q == BURST_TOP && req_a) state_d = GNT_A;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == GNT_A) last_d = LAST_A;
            if (state_d == GNT_B) last_d = LAST_B;
        end else if ((accept_a || accept_b) && burst_cnt_q != BURST_TOP) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    always_comb begin
        wr_en_d   = accept_a | accept_b;
        data_in_d = data_in_q;
        if (accept_a)      data_in_d = data_a;
        else if (accept_b) data_in_d = data_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_B;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_in_q   <= data_in_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign data_in   = data_in_q;
    assign gnt_state = state_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_cnt_a_q, wr_cnt_a_d;
    logic [15:0] wr_cnt_b_q, wr_cnt_b_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        wr_cnt_a_d = wr_cnt_a_q;
        wr_cnt_b_d = wr_cnt_b_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (accept_a && wr_cnt_a_q != '1) wr_cnt_a_d = wr_cnt_a_q + 16'd1;
        if (accept_b && wr_cnt_b_q != '1) wr_cnt_b_d = wr_cnt_b_q + 16'd1;
        if (overflow && ovf_cnt_q != '1)  ovf_cnt_d  = ovf_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_a_q <= '0;
            wr_cnt_b_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            wr_cnt_a_q <= wr_cnt_a_d;
            wr_cnt_b_q <= wr_cnt_b_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign wr_cnt_a = wr_cnt_a_q;
    assign wr_cnt_b = wr_cnt_b_q;
    assign ovf_cnt  = ovf_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = overflow;
    assign wr_cnt_a     = '0;
    assign wr_cnt_b     = '0;
    assign ovf_cnt      = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, giving the data width of each requester and of the FIFO write data.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, legal range 1..15, giving the maximum consecutive accepts per grant while the other requester waits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports req_a and req_b, input, 1, write requests from producers A and B.
REQ-006 The block SHALL have ports data_a and data_b, input, FIFO_WIDTH, write data from producers A and B.
REQ-007 The block SHALL have ports accept_a and accept_b, output, 1, combinational, meaning "data_x taken this cycle".
REQ-008 The block SHALL have ports full, almostfull and overflow, input, 1, FIFO status flags.
REQ-009 The block SHALL have ports wr_en, output, 1, and data_in, output, FIFO_WIDTH, registered FIFO write port.
REQ-010 The block SHALL have ports wr_cnt_a and wr_cnt_b, output, 16, accepted-write counters for A and B.
REQ-011 The block SHALL have port ovf_cnt, output, 8, count of FIFO overflow pulses.
REQ-012 The block SHALL have port gnt_state, output, 2, current state encoding: IDLE=0, GNT_A=1, GNT_B=2.

Function
REQ-013 The FSM SHALL have states IDLE, GNT_A and GNT_B, with a 1-bit last register and a 4-bit burst_cnt.
REQ-014 The block SHALL compute blocked = full | (almostfull & wr_en) to cover the one-cycle write pipeline.
REQ-015 accept_a SHALL = (state==GNT_A) & req_a & ~blocked; accept_b likewise for GNT_B; both SHALL never be high together.
REQ-016 In IDLE, the FSM SHALL go to GNT_A if req_a & (~req_b | last==B), else to GNT_B if req_b, else stay; no accept occurs in IDLE.
REQ-017 In GNT_x, if req_x is low, the FSM SHALL go to GNT_other when the other requester is requesting, else to IDLE.
REQ-018 In GNT_x, if accept_x and burst_cnt==MAX_BURST-1 and the other requester is requesting, the FSM SHALL go to GNT_other; otherwise it SHALL stay.
REQ-019 burst_cnt SHALL increment on each accept, saturate at MAX_BURST-1 when the other requester is idle, and clear on every state change.
REQ-020 last SHALL update to x on entry to GNT_x.
REQ-021 wr_en SHALL be registered (accept_a | accept_b), and data_in SHALL be registered from the accepted data; data_in SHALL hold its value when wr_en is 0.
REQ-022 While blocked, the grant SHALL hold, no accept SHALL occur, and burst_cnt SHALL not advance.
REQ-023 Write latency SHALL be 1 cycle from accept to wr_en at the FIFO.

Reset
REQ-024 When rst_n is low, the block SHALL asynchronously force state=IDLE, last=B, burst_cnt=0, wr_en=0, data_in=0, wr_cnt_a=wr_cnt_b=0 and ovf_cnt=0.
REQ-025 accept_a and accept_b SHALL be 0 during reset; a write accepted in the cycle reset asserts SHALL be discarded, not forwarded.

Configuration
REQ-026 With macro FIFO_ARB_STATS_EN defined, wr_cnt_a and wr_cnt_b SHALL increment on each accept and saturate at 0xFFFF, and ovf_cnt SHALL increment on each cycle with overflow=1 and saturate at 0xFF.
REQ-027 Without FIFO_ARB_STATS_EN, the counters SHALL not be synthesised and wr_cnt_a, wr_cnt_b and ovf_cnt SHALL be tied to 0.

Verification
REQ-028 After reset, req_a=1 and req_b=1 constant with full=0: GNT_A for 4 accepts, then GNT_B for 4 accepts, alternating; wr_en high every cycle after the first grant.
REQ-029 req_a only, data_a=0x1234: 1 IDLE cycle, then accept_a every cycle; the next cycle shows wr_en=1 and data_in=0x1234; burst_cnt stays at 3 with no switch.
REQ-030 In GNT_A with almostfull=1 and wr_en=1: accept_a=0 for that cycle; with full=1 held for 3 cycles: no accepts and state GNT_A held.
REQ-031 Drop req_a mid-burst at burst_cnt=2 with req_b=1: the next state is GNT_B and burst_cnt=0.
REQ-032 Assert rst_n=0 mid-burst: outputs are reset values immediately and wr_en=0 on the following edge.
REQ-033 With FIFO_ARB_STATS_EN, 3 overflow pulses plus 70000 A accepts: ovf_cnt=3 and wr_cnt_a=0xFFFF; without the macro, all counters read 0.
